// File: rtl/operand_ram_pkg.sv
// operand_ram shared types: FSM state and default operand table.
// Exports opr_state_e, OPR_INIT_0..6 and init_value().
package operand_ram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } opr_state_e;

  localparam logic [15:0] OPR_INIT_0 = 16'h000A;
  localparam logic [15:0] OPR_INIT_1 = 16'h000F;
  localparam logic [15:0] OPR_INIT_2 = 16'h0010;
  localparam logic [15:0] OPR_INIT_3 = 16'h0008;
  localparam logic [15:0] OPR_INIT_4 = 16'h00FF;
  localparam logic [15:0] OPR_INIT_5 = 16'h000F;
  localparam logic [15:0] OPR_INIT_6 = 16'h000A;

  // Default contents of one location; everything past entry 6 is zero.
  function automatic logic [15:0] init_value(
    input logic [31:0] addr
  );
    logic [15:0] v;
    case (addr)
      32'd0:   v = OPR_INIT_0;
      32'd1:   v = OPR_INIT_1;
      32'd2:   v = OPR_INIT_2;
      32'd3:   v = OPR_INIT_3;
      32'd4:   v = OPR_INIT_4;
      32'd5:   v = OPR_INIT_5;
      32'd6:   v = OPR_INIT_6;
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/operand_ram_init_fsm.sv
// operand_ram init engine: walks every address writing the default table.
// Ports: clk, rst_n, clr_i in; ready_o, init_we_o/addr_o/data_o out.
module operand_ram_init_fsm
  import operand_ram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  output logic              ready_o,
  output logic              init_we_o,
  output logic [ADDR_W-1:0] init_addr_o,
  output logic [DATA_W-1:0] init_data_o
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  opr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_we_o = 1'b0;
    unique case (state_q)
      INIT: begin
        init_we_o = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: begin
        if (clr_i) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready_o     = (state_q == READY);
  assign init_addr_o = cnt_q;
  // Table is 16 bits wide; narrower words truncate, wider ones zero-extend.
  assign init_data_o = DATA_W'(init_value(32'(cnt_q)));

endmodule

// File: rtl/operand_ram.sv
// operand_ram: 1W/2R synchronous operand store with built-in init engine.
// Ports: clr, rd_en/addr/data/valid on A and B, wr_en/addr/data, ready, reject.
module operand_ram
  import operand_ram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ready,
  output logic              reject
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;

  operand_ram_init_fsm #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_init (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr),
    .ready_o     (ready),
    .init_we_o   (init_we),
    .init_addr_o (init_addr),
    .init_data_o (init_data)
  );

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              acc;
  logic              rd_a_ok, rd_b_ok, wr_ok;
  logic              any_req;
  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
  logic              rd_valid_a_q, rd_valid_b_q;
  logic              reject_q;

  // A clr edge drops user traffic just like INIT does.
  assign acc     = ready & ~clr;
  assign rd_a_ok = rd_en_a & acc;
  assign rd_b_ok = rd_en_b & acc;
  assign wr_ok   = wr_en & acc;
  assign any_req = rd_en_a | rd_en_b | wr_en;

  always_comb begin
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    if (rd_a_ok) begin
      if (BYPASS && wr_ok && (wr_addr == rd_addr_a))
        rd_data_a_d = wr_data;
      else
        rd_data_a_d = mem_q[rd_addr_a];
    end
    if (rd_b_ok) begin
      if (BYPASS && wr_ok && (wr_addr == rd_addr_b))
        rd_data_b_d = wr_data;
      else
        rd_data_b_d = mem_q[rd_addr_b];
    end
  end

  // Storage carries no reset; contents are defined by the init walk.
  always_ff @(posedge clk) begin
    if (init_we)
      mem_q[init_addr] <= init_data;
    else if (wr_ok)
      mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
      reject_q     <= 1'b0;
    end else begin
      rd_data_a_q  <= rd_data_a_d;
      rd_data_b_q  <= rd_data_b_d;
      rd_valid_a_q <= rd_a_ok;
      rd_valid_b_q <= rd_b_ok;
      reject_q     <= any_req & ~acc;
    end
  end

  assign rd_data_a  = rd_data_a_q;
  assign rd_data_b  = rd_data_b_q;
  assign rd_valid_a = rd_valid_a_q;
  assign rd_valid_b = rd_valid_b_q;
  assign reject     = reject_q;

endmodule

// File: tb/tb_operand_ram.sv
// Directed bench for operand_ram, BYPASS=1 and BYPASS=0 side by side.
// Both instances share stimulus; outputs are checked against constants.
module tb_operand_ram;

  logic        clk = 1'b0;
  logic        rst_n, clr;
  logic        rd_en_a, rd_en_b, wr_en;
  logic [3:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0] wr_data;

  logic [15:0] rd_data_a, rd_data_b, rd_data_a0, rd_data_b0;
  logic        rd_valid_a, rd_valid_b, rd_valid_a0, rd_valid_b0;
  logic        ready, reject, ready0, reject0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  operand_ram #(.DATA_W(16), .ADDR_W(4), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
    .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ready(ready), .reject(reject)
  );

  operand_ram #(.DATA_W(16), .ADDR_W(4), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
    .rd_data_a(rd_data_a0), .rd_valid_a(rd_valid_a0),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .rd_data_b(rd_data_b0), .rd_valid_b(rd_valid_b0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ready(ready0), .reject(reject0)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 0; rd_en_a = 0; rd_en_b = 0; wr_en = 0;
  endtask

  // Edges until ready rises, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!ready && n < 40);
  endtask

  task automatic rd_a(input logic [3:0] a);
    rd_en_a = 1; rd_addr_a = a;
    cyc();
    rd_en_a = 0;
  endtask

  int n;

  initial begin
    rst_n = 0; idle();
    rd_addr_a = 0; rd_addr_b = 0; wr_addr = 0; wr_data = 0;

    // 1: reset, init walk, dual read
    cyc(); cyc();
    check("rst_ready", ready, 0);
    check("rst_reject", reject, 0);
    check("rst_valid_a", rd_valid_a, 0);
    check("rst_data_a", rd_data_a, 0);
    check("rst_data_b", rd_data_b, 0);
    rst_n = 1;
    wait_ready(n);
    check("init_len", n, 16);
    check("init_len_b0", ready0, 1);

    rd_en_a = 1; rd_addr_a = 4;
    rd_en_b = 1; rd_addr_b = 1;
    cyc(); idle();
    check("rd_a4", rd_data_a, 16'h00FF);
    check("vld_a", rd_valid_a, 1);
    check("rd_b1", rd_data_b, 16'h000F);
    check("vld_b", rd_valid_b, 1);
    cyc();
    check("vld_a_drop", rd_valid_a, 0);
    check("vld_b_drop", rd_valid_b, 0);
    check("hold_a", rd_data_a, 16'h00FF);
    check("idle_reject", reject, 0);
    rd_a(9);
    check("rd_a9", rd_data_a, 16'h0000);

    rd_en_a = 1; rd_addr_a = 6;
    rd_en_b = 1; rd_addr_b = 6;
    cyc(); idle();
    check("same_a6", rd_data_a, 16'h000A);
    check("same_b6", rd_data_b, 16'h000A);

    // 2: write then read
    wr_en = 1; wr_addr = 7; wr_data = 16'h1234;
    cyc(); idle();
    check("wr_reject", reject, 0);
    rd_a(7);
    check("rd_a7", rd_data_a, 16'h1234);
    check("rd_a7_vld", rd_valid_a, 1);
    rd_a(0);
    check("rd_a0", rd_data_a, 16'h000A);

    // 3: same-edge write/read
    wr_en = 1; wr_addr = 2; wr_data = 16'hBEEF;
    rd_en_a = 1; rd_addr_a = 2;
    cyc(); idle();
    check("byp1", rd_data_a, 16'hBEEF);
    check("byp0", rd_data_a0, 16'h0010);
    rd_a(2);
    check("byp0_2nd", rd_data_a0, 16'hBEEF);

    // 5: write, then clr with concurrent write
    wr_en = 1; wr_addr = 3; wr_data = 16'h5555;
    cyc(); idle();
    rd_a(3);
    check("rd_a3_w", rd_data_a, 16'h5555);
    clr = 1; wr_en = 1; wr_addr = 3; wr_data = 16'h1111;
    cyc(); idle();
    check("clr_reject", reject, 1);
    check("clr_ready", ready, 0);

    // 4: requests during INIT (edge 5 after the clr edge)
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        wr_en = 1; wr_addr = 2; wr_data = 16'h7777;
        rd_en_a = 1; rd_addr_a = 0;
      end
      cyc(); idle();
      if (k == 1) check("clr_rej_end", reject, 0);
      if (k == 5) begin
        check("init_reject", reject, 1);
        check("init_no_vld", rd_valid_a, 0);
        check("init_no_vld0", rd_valid_a0, 0);
      end
      if (k == 6) check("init_rej_end", reject, 0);
      if (ready) begin
        n = k;
        break;
      end
    end
    check("clr_len", n, 16);
    rd_a(3);
    check("rd_a3_clr", rd_data_a, 16'h0008);
    rd_a(2);
    check("rd_a2_clr", rd_data_a, 16'h0010);
    rd_a(7);
    check("rd_a7_clr", rd_data_a, 16'h0000);

    // 6: reset in the middle of INIT
    rst_n = 0; cyc(); rst_n = 1;
    for (int k = 0; k < 8; k++) cyc();
    check("mid_ready", ready, 0);
    rst_n = 0; cyc(); rst_n = 1;
    check("rst2_data_a", rd_data_a, 0);
    wait_ready(n);
    check("rst2_len", n, 16);
    rd_a(5);
    check("rd_a5", rd_data_a, 16'h000F);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
